// File: rtl/alu_seq.sv
// Sequential ALU with a ready/valid handshake on both sides. Rotations walk
// one bit per clock under a down-counter, and all other operations finish in one cycle.
//
// state | meaning
// IDLE  | ready for a request (in_ready=1)
// ROT   | rotating res one bit per edge until the counter expires
// DONE  | result held until the consumer takes it (out_valid=1)
module alu_seq #(
  parameter int WIDTH = 10,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             s,
  output logic             g,
  output logic             z,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [OPW-1:0] OP_DEC_A = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_DEC_B = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_XOR_A = OPW'(5'b00111);
  localparam logic [OPW-1:0] OP_XOR_B = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_NAND_A = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_NAND_B = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_ROR_A = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_ROR_B = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_ROL   = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_INC   = OPW'(5'b10010);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rol_q, rol_d;
  logic             g_q, g_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic             is_rot;
  logic             rol_sel;
  logic [31:0]      op2_ext;
  logic [CW-1:0]    amt;
  logic [WIDTH-1:0] rotr1, rotl1;

  assign op2_ext = 32'(op2);
  assign amt     = CW'(op2_ext % 32'(WIDTH));
  assign rotr1   = {res_q[0], res_q[WIDTH-1:1]};
  assign rotl1   = {res_q[WIDTH-2:0], res_q[WIDTH-1]};

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    is_rot  = 1'b0;
    rol_sel = 1'b0;
    case (opcode)
      OP_DEC_A, OP_DEC_B:   alu_res = op1 - ONE;
      OP_XOR_A, OP_XOR_B:   alu_res = op1 ^ op2;
      OP_NAND_A, OP_NAND_B: alu_res = ~(op1 & op2);
      OP_ROR_A, OP_ROR_B:   is_rot = 1'b1;
      OP_ROL: begin
        is_rot  = 1'b1;
        rol_sel = 1'b1;
      end
      OP_INC:               alu_res = op1 + ONE;
      default:              alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    rol_d   = rol_q;
    g_d     = g_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          g_d   = $signed(op1) > $signed(op2);
          err_d = alu_err;
          rol_d = rol_sel;
          if (is_rot) begin
            res_d   = op1;
            cnt_d   = amt;
            state_d = (amt == '0) ? DONE : ROT;
          end else begin
            res_d   = alu_res;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      ROT: begin
        res_d = rol_q ? rotl1 : rotr1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      rol_q   <= 1'b0;
      g_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      rol_q   <= rol_d;
      g_q     <= g_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
  assign s         = res_q[WIDTH-1];
  assign z         = (res_q == '0);
  assign g         = g_q;
  assign err       = err_q;

endmodule
